// File: rtl/alsaqr_pad_gpio_pkg.sv
// Shared constants for the AlSaqr pad GPIO controller: register map and DRV field width.
// No logic beyond a small address-normalising helper.
package alsaqr_pad_gpio_pkg;

  localparam int unsigned DRV_W = 2;
  localparam int unsigned REG_W = 32;

  localparam logic [5:0] ADDR_DIR     = 6'h00;
  localparam logic [5:0] ADDR_OUT     = 6'h04;
  localparam logic [5:0] ADDR_IN      = 6'h08;
  localparam logic [5:0] ADDR_PUEN    = 6'h0C;
  localparam logic [5:0] ADDR_SLW     = 6'h10;
  localparam logic [5:0] ADDR_SMT     = 6'h14;
  localparam logic [5:0] ADDR_DRV     = 6'h18;
  localparam logic [5:0] ADDR_RISE_EN = 6'h1C;
  localparam logic [5:0] ADDR_FALL_EN = 6'h20;
  localparam logic [5:0] ADDR_STATUS  = 6'h24;

  // Byte lanes are not decoded; accesses resolve to the containing word.
  function automatic logic [5:0] word_addr(input logic [5:0] addr);
    return {addr[5:2], 2'b00};
  endfunction

endpackage

// File: rtl/alsaqr_pad_debounce.sv
// One pad input: 2-flop synchronizer, DEBOUNCE_CYCLES mismatch counter, edge pulses.
// stable_o lags the pad by 2+DEBOUNCE_CYCLES edges; rise_o/fall_o are one-cycle pulses; no backpressure.
module alsaqr_pad_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q, sync2_q;
  logic       stable_q, stable_d;
  logic       stable_dly_q;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= pad_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  // Edges are taken against a delayed copy so STATUS lands one edge after stable.
  assign stable_o = stable_q;
  assign rise_o   = stable_q & ~stable_dly_q;
  assign fall_o   = ~stable_q & stable_dly_q;

endmodule

// File: rtl/alsaqr_pad_gpio_ctrl.sv
// Register-programmed GPIO controller driving AlSaqr pad controls, with debounced inputs and edge IRQ.
// Register responses one cycle after each request; gnt_o is tied high so no backpressure.
module alsaqr_pad_gpio_ctrl
  import alsaqr_pad_gpio_pkg::*;
#(
  parameter int unsigned NUM_PADS        = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_i,
  input  logic                        we_i,
  input  logic [5:0]                  addr_i,
  input  logic [31:0]                 wdata_i,
  output logic                        gnt_o,
  output logic                        rvalid_o,
  output logic [31:0]                 rdata_o,
  output logic                        err_o,
  output logic [NUM_PADS-1:0]         pad_oen_o,
  output logic [NUM_PADS-1:0]         pad_i_o,
  output logic [NUM_PADS-1:0]         pad_puen_o,
  output logic [DRV_W*NUM_PADS-1:0]   pad_drv_o,
  output logic [NUM_PADS-1:0]         pad_slw_o,
  output logic [NUM_PADS-1:0]         pad_smt_o,
  input  logic [NUM_PADS-1:0]         pad_o_i,
  output logic                        irq_o
);

  localparam int unsigned NP = NUM_PADS;
  localparam int unsigned DB = DRV_W * NUM_PADS;

  logic [NP-1:0] dir_q, dir_d;
  logic [NP-1:0] out_q, out_d;
  logic [NP-1:0] puen_q, puen_d;
  logic [NP-1:0] slw_q, slw_d;
  logic [NP-1:0] smt_q, smt_d;
  logic [DB-1:0] drv_q, drv_d;
  logic [NP-1:0] rise_en_q, rise_en_d;
  logic [NP-1:0] fall_en_q, fall_en_d;
  logic [NP-1:0] status_q, status_d;

  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [NP-1:0] in_val;
  logic [NP-1:0] rise_evt;
  logic [NP-1:0] fall_evt;

  for (genvar k = 0; k < NP; k++) begin : g_pad
    alsaqr_pad_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .pad_i   (pad_o_i[k]),
      .stable_o(in_val[k]),
      .rise_o  (rise_evt[k]),
      .fall_o  (fall_evt[k])
    );
  end

  always_comb begin
    dir_d     = dir_q;
    out_d     = out_q;
    puen_d    = puen_q;
    slw_d     = slw_q;
    smt_d     = smt_q;
    drv_d     = drv_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    status_d  = status_q;
    rvalid_d  = req_i;
    rdata_d   = '0;
    err_d     = 1'b0;

    // Read data is taken from the current registers, so a same-cycle write is not visible.
    if (req_i) begin
      unique case (word_addr(addr_i))
        ADDR_DIR: begin
          rdata_d[NP-1:0] = dir_q;
          if (we_i) dir_d = wdata_i[NP-1:0];
        end
        ADDR_OUT: begin
          rdata_d[NP-1:0] = out_q;
          if (we_i) out_d = wdata_i[NP-1:0];
        end
        ADDR_IN: begin
          rdata_d[NP-1:0] = in_val;
        end
        ADDR_PUEN: begin
          rdata_d[NP-1:0] = puen_q;
          if (we_i) puen_d = wdata_i[NP-1:0];
        end
        ADDR_SLW: begin
          rdata_d[NP-1:0] = slw_q;
          if (we_i) slw_d = wdata_i[NP-1:0];
        end
        ADDR_SMT: begin
          rdata_d[NP-1:0] = smt_q;
          if (we_i) smt_d = wdata_i[NP-1:0];
        end
        ADDR_DRV: begin
          rdata_d[DB-1:0] = drv_q;
          if (we_i) drv_d = wdata_i[DB-1:0];
        end
        ADDR_RISE_EN: begin
          rdata_d[NP-1:0] = rise_en_q;
          if (we_i) rise_en_d = wdata_i[NP-1:0];
        end
        ADDR_FALL_EN: begin
          rdata_d[NP-1:0] = fall_en_q;
          if (we_i) fall_en_d = wdata_i[NP-1:0];
        end
        ADDR_STATUS: begin
          rdata_d[NP-1:0] = status_q;
          if (we_i) status_d = status_q & ~wdata_i[NP-1:0];
        end
        default: begin
          err_d = 1'b1;
        end
      endcase
      if (we_i) rdata_d = '0;
    end

    // New edges are merged after the W1C so a coincident set survives the clear.
    status_d = status_d | (rise_evt & rise_en_q) | (fall_evt & fall_en_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dir_q     <= '0;
      out_q     <= '0;
      puen_q    <= '0;
      slw_q     <= '0;
      smt_q     <= '0;
      drv_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      dir_q     <= dir_d;
      out_q     <= out_d;
      puen_q    <= puen_d;
      slw_q     <= slw_d;
      smt_q     <= smt_d;
      drv_q     <= drv_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{addr_i[1:0], wdata_i};

  assign gnt_o      = 1'b1;
  assign rvalid_o   = rvalid_q;
  assign rdata_o    = rdata_q;
  assign err_o      = err_q;
  assign pad_oen_o  = ~dir_q;
  assign pad_i_o    = out_q;
  assign pad_puen_o = puen_q;
  assign pad_drv_o  = drv_q;
  assign pad_slw_o  = slw_q;
  assign pad_smt_o  = smt_q;
  assign irq_o      = |status_q;

endmodule

// File: tb/tb_alsaqr_pad_gpio_ctrl.sv
// Directed bench for alsaqr_pad_gpio_ctrl: register access, pad mapping, debounce timing, IRQ and reset.
module tb_alsaqr_pad_gpio_ctrl;
  import alsaqr_pad_gpio_pkg::*;

  localparam int NP = 16;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            req_i;
  logic            we_i;
  logic [5:0]      addr_i;
  logic [31:0]     wdata_i;
  logic            gnt_o;
  logic            rvalid_o;
  logic [31:0]     rdata_o;
  logic            err_o;
  logic [NP-1:0]   pad_oen_o;
  logic [NP-1:0]   pad_i_o;
  logic [NP-1:0]   pad_puen_o;
  logic [2*NP-1:0] pad_drv_o;
  logic [NP-1:0]   pad_slw_o;
  logic [NP-1:0]   pad_smt_o;
  logic [NP-1:0]   pad_o_i;
  logic            irq_o;

  logic [NP-1:0]   pad_ext;
  int              vectors = 0;
  int              miscompares = 0;

  // Pads driven as outputs loop back; input pads see the external stimulus.
  assign pad_o_i = (pad_i_o & ~pad_oen_o) | (pad_ext & pad_oen_o);

  always #5 clk_i = ~clk_i;

  alsaqr_pad_gpio_ctrl #(
    .NUM_PADS(NP),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .pad_oen_o(pad_oen_o), .pad_i_o(pad_i_o), .pad_puen_o(pad_puen_o),
    .pad_drv_o(pad_drv_o), .pad_slw_o(pad_slw_o), .pad_smt_o(pad_smt_o),
    .pad_o_i(pad_o_i), .irq_o(irq_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic wr(input string tag, input logic [5:0] a, input logic [31:0] d, input logic exp_err);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    @(posedge clk_i);
    @(negedge clk_i);
    req_i = 1'b0; we_i = 1'b0;
    chk({tag, ".rvalid"}, 32'(rvalid_o), 32'd1);
    chk({tag, ".err"}, 32'(err_o), 32'(exp_err));
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp_d, input logic exp_err);
    req_i = 1'b1; we_i = 1'b0; addr_i = a; wdata_i = '0;
    @(posedge clk_i);
    @(negedge clk_i);
    req_i = 1'b0;
    chk({tag, ".rvalid"}, 32'(rvalid_o), 32'd1);
    chk({tag, ".rdata"}, rdata_o, exp_d);
    chk({tag, ".err"}, 32'(err_o), 32'(exp_err));
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; pad_ext = '0;
    repeat (3) @(negedge clk_i);
    chk("rst.oen", 32'(pad_oen_o), 32'h0000_FFFF);
    chk("rst.irq", 32'(irq_o), 32'd0);
    chk("rst.rvalid", 32'(rvalid_o), 32'd0);
    chk("rst.gnt", 32'(gnt_o), 32'd1);
    rst_i = 1'b0;
    @(negedge clk_i);
    rd("rst.dir", ADDR_DIR, 32'h0, 1'b0);
    rd("rst.out", ADDR_OUT, 32'h0, 1'b0);
    rd("rst.in", ADDR_IN, 32'h0, 1'b0);
    rd("rst.status", ADDR_STATUS, 32'h0, 1'b0);

    // Output mapping and loopback latency into IN
    wr("w.dir", ADDR_DIR, 32'h0000_0005, 1'b0);
    chk("map.oen", 32'(pad_oen_o), 32'h0000_FFFA);
    wr("w.out", ADDR_OUT, 32'h0000_0004, 1'b0);
    chk("map.pad_i", 32'(pad_i_o), 32'h0000_0004);
    rd("lb.in_e1", ADDR_IN, 32'h0, 1'b0);
    repeat (4) @(negedge clk_i);
    rd("lb.in_e6", ADDR_IN, 32'h0, 1'b0);
    rd("lb.in_e7", ADDR_IN, 32'h0000_0004, 1'b0);

    // Rising edge on pad 1 raises IRQ at edge 7
    wr("w.rise_en", ADDR_RISE_EN, 32'h0000_0002, 1'b0);
    pad_ext[1] = 1'b1;
    repeat (6) @(negedge clk_i);
    chk("rise.irq_e6", 32'(irq_o), 32'd0);
    @(negedge clk_i);
    chk("rise.irq_e7", 32'(irq_o), 32'd1);
    rd("rise.status", ADDR_STATUS, 32'h0000_0002, 1'b0);
    wr("w.rise_en_off", ADDR_RISE_EN, 32'h0, 1'b0);
    rd("rise.status_kept", ADDR_STATUS, 32'h0000_0002, 1'b0);
    wr("w.w1c", ADDR_STATUS, 32'h0000_0002, 1'b0);
    chk("w1c.irq", 32'(irq_o), 32'd0);
    rd("rise.in", ADDR_IN, 32'h0000_0006, 1'b0);

    // 3-cycle glitch is filtered, 4-cycle pulse is not
    wr("w.rise_en3", ADDR_RISE_EN, 32'h0000_0008, 1'b0);
    wr("w.fall_en3", ADDR_FALL_EN, 32'h0000_0008, 1'b0);
    pad_ext[3] = 1'b1;
    repeat (3) @(negedge clk_i);
    pad_ext[3] = 1'b0;
    repeat (8) @(negedge clk_i);
    chk("glitch.irq", 32'(irq_o), 32'd0);
    rd("glitch.status", ADDR_STATUS, 32'h0, 1'b0);
    rd("glitch.in", ADDR_IN, 32'h0000_0006, 1'b0);
    pad_ext[3] = 1'b1;
    repeat (4) @(negedge clk_i);
    pad_ext[3] = 1'b0;
    repeat (10) @(negedge clk_i);
    rd("pulse4.status", ADDR_STATUS, 32'h0000_0008, 1'b0);
    rd("pulse4.in", ADDR_IN, 32'h0000_0006, 1'b0);
    wr("w.w1c3", ADDR_STATUS, 32'h0000_0008, 1'b0);
    chk("pulse4.irq_clr", 32'(irq_o), 32'd0);

    // Decode: unmapped, read-only IN, upper bits, DRV packing, other pad controls
    rd("unmapped.rd", 6'h3C, 32'h0, 1'b1);
    wr("unmapped.wr", 6'h3C, 32'hFFFF_FFFF, 1'b1);
    wr("w.in_ro", ADDR_IN, 32'hFFFF_FFFF, 1'b0);
    rd("in_ro.in", ADDR_IN, 32'h0000_0006, 1'b0);
    wr("w.dir_hi", ADDR_DIR, 32'hFFFF_0005, 1'b0);
    rd("dir_hi.rd", ADDR_DIR, 32'h0000_0005, 1'b0);
    wr("w.drv", ADDR_DRV, 32'hFFFF_FFFF, 1'b0);
    chk("drv.pad", pad_drv_o, 32'hFFFF_FFFF);
    rd("drv.rd", ADDR_DRV, 32'hFFFF_FFFF, 1'b0);
    wr("w.puen", ADDR_PUEN, 32'h0000_1234, 1'b0);
    chk("puen.pad", 32'(pad_puen_o), 32'h0000_1234);
    wr("w.slw", ADDR_SLW, 32'h0000_00F0, 1'b0);
    chk("slw.pad", 32'(pad_slw_o), 32'h0000_00F0);
    wr("w.smt", ADDR_SMT, 32'h0000_8001, 1'b0);
    chk("smt.pad", 32'(pad_smt_o), 32'h0000_8001);

    // Edge on pad 0 coincides with a W1C of bit 0: the set wins
    wr("w.rise_en0", ADDR_RISE_EN, 32'h0000_0001, 1'b0);
    wr("w.out0", ADDR_OUT, 32'h0000_0005, 1'b0);
    repeat (6) @(negedge clk_i);
    wr("w.w1c0", ADDR_STATUS, 32'h0000_0001, 1'b0);
    chk("race.irq", 32'(irq_o), 32'd1);
    rd("race.status", ADDR_STATUS, 32'h0000_0001, 1'b0);

    // Reset during a pending read discards the response
    req_i = 1'b1; we_i = 1'b0; addr_i = ADDR_STATUS; rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    req_i = 1'b0; rst_i = 1'b0;
    chk("mrst.rvalid", 32'(rvalid_o), 32'd0);
    chk("mrst.rdata", rdata_o, 32'h0);
    chk("mrst.err", 32'(err_o), 32'd0);
    chk("mrst.irq", 32'(irq_o), 32'd0);
    chk("mrst.oen", 32'(pad_oen_o), 32'h0000_FFFF);
    chk("mrst.pad_i", 32'(pad_i_o), 32'h0);
    chk("mrst.drv", pad_drv_o, 32'h0);
    chk("mrst.puen", 32'(pad_puen_o), 32'h0);
    rd("mrst.dir", ADDR_DIR, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alsaqr_pad_gpio_ctrl.md
# alsaqr_pad_gpio_ctrl

Register-programmed GPIO controller that sits directly upstream of the AlSaqr I/O pad cells. It drives each pad's OEN, I, PUEN, DRV, SLW and SMT controls from configuration registers. It also samples each pad's O return through a synchronizer and debouncer, and raises a level interrupt on enabled rising or falling edges. One instance serves NUM_PADS pads over a simple request/response register port.

## Interface
Parameters:
- NUM_PADS, 16: number of pads served; legal range 1..16, because DRV is packed 2 bits per pad into one 32-bit word.
- DEBOUNCE_CYCLES, 4: consecutive mismatch cycles required before the debounced input changes; legal range 1..255.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high, single clock domain
- req_i  in  1  register access request
- we_i  in  1  1 = write, 0 = read
- addr_i  in  6  byte address; bits [1:0] ignored
- wdata_i  in  32  write data
- gnt_o  out  1  grant; tied high
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data
- err_o  out  1  unmapped access flag, valid together with rvalid_o
- pad_oen_o  out  NUM_PADS  per-pad output enable to the pad, active low
- pad_i_o  out  NUM_PADS  per-pad output data to the pad
- pad_puen_o  out  NUM_PADS  per-pad pull enable
- pad_drv_o  out  2*NUM_PADS  per-pad drive strength; pad k uses bits [2k+1:2k]
- pad_slw_o  out  NUM_PADS  per-pad slew control
- pad_smt_o  out  NUM_PADS  per-pad Schmitt trigger enable
- pad_o_i  in  NUM_PADS  per-pad input value returned from the pad (asynchronous)
- irq_o  out  1  interrupt; OR of all status bits

## Operation
- Register map (word offsets; bits at or above NUM_PADS read 0 and ignore writes):
  - 0x00 DIR (1 = output)
  - 0x04 OUT
  - 0x08 IN (read-only, debounced value)
  - 0x0C PUEN
  - 0x10 SLW
  - 0x14 SMT
  - 0x18 DRV (packed)
  - 0x1C RISE_EN
  - 0x20 FALL_EN
  - 0x24 STATUS (write-1-to-clear)
- Output mapping, all directly from registers:
  - pad_oen_o = ~DIR
  - pad_i_o = OUT
  - The remaining pad controls equal their registers.
- Input path, per pad:
  - Two-flop synchronizer stage sync1 → sync2.
  - Debouncer holds a stable value and an 8-bit counter.
  - Counting: while sync2 ≠ stable, the counter increments each cycle. When the counter reaches DEBOUNCE_CYCLES−1 and sync2 still differs, stable ← sync2 and the counter clears.
  - Any cycle with sync2 = stable clears the counter.
- Edge detect on stable:
  - A 0→1 transition with RISE_EN[k] set sets STATUS[k].
  - A 1→0 transition with FALL_EN[k] set sets STATUS[k].
- The input is sampled regardless of DIR, so output loopback is visible in IN.
- Writes to IN are ignored and return err_o = 0.
- Unmapped addresses: writes are dropped; reads return 0; err_o = 1.
- Reset values:
  - All registers 0, so pad_oen_o is all ones (every pad is an input).
  - sync1, sync2, stable and counters are 0.
  - rvalid_o, rdata_o, err_o and irq_o are 0.

## Timing
- gnt_o is constantly 1, so every req_i cycle is accepted.
- Responses:
  - rvalid_o pulses exactly one cycle after each accepted request, for reads and writes.
  - rdata_o and err_o are registered and valid only while rvalid_o is high.
  - Back-to-back requests produce back-to-back responses.
- A write accepted at edge t updates the register and the pad outputs after edge t.
- A read in the same cycle as a write to the same register returns the old value.
- Pad input latency: a change of pad_o_i, held stable, is captured by sync1 at edge 1 and by sync2 at edge 2. stable updates at edge 2+DEBOUNCE_CYCLES, and STATUS/irq_o update at edge 3+DEBOUNCE_CYCLES (edge 6 and edge 7 for the default of 4).
- A glitch shorter than DEBOUNCE_CYCLES cycles after synchronization never changes stable.
- If an edge sets STATUS[k] in the same cycle a W1C write clears bit k, the set wins.
- Disabling RISE_EN/FALL_EN does not clear pending STATUS bits.
- Asserting rst_i mid-operation forces all reset values at the next edge. A request accepted in that cycle is discarded, with no rvalid_o.

## Structure
- Package alsaqr_pad_gpio_pkg holds:
  - the register offset localparams (ADDR_DIR … ADDR_STATUS);
  - the DRV width constant (2).
- Sub-module alsaqr_pad_debounce: one pad's synchronizer, counter, stable register and rise/fall pulse outputs. It is instantiated NUM_PADS times through a generate loop.
- The top level contains the register file, the address decode and the response register.

## Test plan
- Reset, then read DIR/OUT/IN/STATUS → all 0 with err_o = 0; pad_oen_o = all ones; irq_o = 0.
- Write DIR = 0x0005 and OUT = 0x0004 → pad_oen_o = 0xFFFA and pad_i_o = 0x0004 after the write edge; with pad_o_i looped back, IN reads 0x0004 no earlier than edge 6.
- With RISE_EN = 0x0002, drive pad_o_i[1] 0→1 and hold → STATUS = 0x0002 and irq_o = 1 at edge 7. Write STATUS = 0x0002 → irq_o = 0 on the next edge.
- Pulse pad_o_i[3] high for 3 cycles with FALL_EN and RISE_EN both set → IN[3] stays 0 and STATUS stays 0.
- Read address 0x3C → rvalid_o one cycle later, rdata_o = 0, err_o = 1. Write DRV = 0xFFFFFFFF → pad_drv_o reads back all ones across 2*NUM_PADS bits.
- Rising edge on pad 0 landing in the same cycle as a STATUS = 0x1 W1C write → STATUS[0] remains 1. Assert rst_i during a pending read → no rvalid_o, and all outputs return to reset values.
